// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vpu_pkg
// Brief   : Shared SEW encodings, sequencer state type and SEW helper.
// Revision: 1.0  initial release
// ============================================================================
package vpu_pkg;

    localparam logic [1:0] c_sew_8  = 2'b00;
    localparam logic [1:0] c_sew_16 = 2'b01;
    localparam logic [1:0] c_sew_32 = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The reserved encoding 2'b11 behaves as 32-bit elements.
    function automatic logic [2:0] sew_bytes(input logic [1:0] sew);
        case (sew)
            c_sew_8:  return 3'd1;
            c_sew_16: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_byte_enable_gen.sv
`default_nettype none
// ============================================================================
// Module  : vpu_byte_enable_gen
// Brief   : Per-byte register write flags for one result beat.
// Revision: 1.0  initial release
// ============================================================================
module vpu_byte_enable_gen
    import vpu_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int NBEATS = VLEN / 32,
    parameter int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    parameter int VLW    = $clog2(VLEN) + 1
) (
    input  logic [IW-1:0]     i_beat_idx,
    input  logic [VLW-1:0]    i_vl_eff,
    input  logic [1:0]        i_sew,
    input  logic              i_vm,
    input  logic [VLEN/8-1:0] i_mask,
    input  logic              i_mask_dest,
    output logic [VLEN/8-1:0] o_flag
);

    // Byte b only ever belongs to beat b/4, so every element index is a constant.
    generate
        for (genvar b = 0; b < VLEN / 8; b++) begin : g_byte
            localparam logic [IW-1:0]  c_beat = IW'(b / 4);
            localparam logic [VLW-1:0] c_e8   = VLW'(b);
            localparam logic [VLW-1:0] c_e16  = VLW'(b / 2);
            localparam logic [VLW-1:0] c_e32  = VLW'(b / 4);
            localparam logic [VLW-1:0] c_bit  = VLW'(8 * b);

            logic w_norm;

            always_comb begin
                case (i_sew)
                    c_sew_8:  w_norm = (c_e8  < i_vl_eff) && (i_vm || i_mask[b]);
                    c_sew_16: w_norm = (c_e16 < i_vl_eff) && (i_vm || i_mask[b / 2]);
                    default:  w_norm = (c_e32 < i_vl_eff) && (i_vm || i_mask[b / 4]);
                endcase
            end

            assign o_flag[b] = (i_beat_idx == c_beat) &&
                               (i_mask_dest ? (c_bit < i_vl_eff) : w_norm);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vector_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vector_writeback_sequencer
// Brief   : Turns a writeback job plus ALU result beats into register-file writes.
// Revision: 1.0  initial release
// ============================================================================
module vector_writeback_sequencer
    import vpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int VLEN  = 128
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_job_valid,
    output logic                     o_job_ready,
    input  logic [$clog2(WIDTH)-1:0] i_job_vd,
    input  logic [$clog2(VLEN):0]    i_job_vl,
    input  logic [1:0]               i_job_sew,
    input  logic                     i_job_vm,
    input  logic                     i_job_mask_dest,
    input  logic [VLEN-1:0]          i_mask,
    input  logic                     i_res_valid,
    output logic                     o_res_ready,
    input  logic [WIDTH-1:0]         i_res_data,
    output logic [WIDTH-1:0]         o_wr_data,
    output logic [VLEN/8-1:0]        o_wr_flag,
    output logic                     o_update_vreg,
    output logic                     o_update_mask,
    output logic [$clog2(WIDTH)-1:0] o_wr_addr,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int AW     = $clog2(WIDTH);
    localparam int VLW    = $clog2(VLEN) + 1;
    localparam int NBYTES = VLEN / 8;
    localparam int NBEATS = VLEN / 32;
    localparam int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CW     = VLW + 3;

    state_t              r_state;
    logic [AW-1:0]       r_vd;
    logic [1:0]          r_sew;
    logic                r_vm;
    logic                r_mask_dest;
    logic [NBYTES-1:0]   r_mask;
    logic [VLW-1:0]      r_vl_eff;
    logic [IW-1:0]       r_beat_idx;
    logic [IW-1:0]       r_beat_last;
    logic [WIDTH-1:0]    r_wr_data;
    logic [NBYTES-1:0]   r_wr_flag;
    logic                r_update_vreg;
    logic                r_update_mask;
    logic [AW-1:0]       r_wr_addr;
    logic                r_done;

    logic [VLW-1:0]      w_vlmax;
    logic [VLW-1:0]      w_vl_eff;
    logic [CW-1:0]       w_nbytes;
    logic [CW-1:0]       w_nbeats;
    logic [IW-1:0]       w_last;
    logic [NBYTES-1:0]   w_flag;
    logic                w_vd_nz;
    logic                w_unused_mask;

    // Only the first VLEN/8 mask bits can ever select an element.
    assign w_unused_mask = ^i_mask[VLEN-1:NBYTES];

    always_comb begin
        if (i_job_mask_dest) begin
            w_vlmax = VLW'(VLEN);
        end else begin
            case (i_job_sew)
                c_sew_8:  w_vlmax = VLW'(VLEN / 8);
                c_sew_16: w_vlmax = VLW'(VLEN / 16);
                default:  w_vlmax = VLW'(VLEN / 32);
            endcase
        end
        w_vl_eff = (i_job_vl > w_vlmax) ? w_vlmax : i_job_vl;
        w_nbytes = CW'(w_vl_eff) * CW'(sew_bytes(i_job_sew));
        if (i_job_mask_dest) begin
            w_nbeats = (CW'(w_vl_eff) + CW'(31)) >> 5;
        end else begin
            w_nbeats = (w_nbytes + CW'(3)) >> 2;
        end
        w_last = IW'(w_nbeats - CW'(1));
    end

    vpu_byte_enable_gen #(
        .VLEN (VLEN)
    ) u_byte_enable_gen (
        .i_beat_idx  (r_beat_idx),
        .i_vl_eff    (r_vl_eff),
        .i_sew       (r_sew),
        .i_vm        (r_vm),
        .i_mask      (r_mask),
        .i_mask_dest (r_mask_dest),
        .o_flag      (w_flag)
    );

    assign w_vd_nz = (r_vd != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_vd          <= '0;
            r_sew         <= '0;
            r_vm          <= 1'b0;
            r_mask_dest   <= 1'b0;
            r_mask        <= '0;
            r_vl_eff      <= '0;
            r_beat_idx    <= '0;
            r_beat_last   <= '0;
            r_wr_data     <= '0;
            r_wr_flag     <= '0;
            r_update_vreg <= 1'b0;
            r_update_mask <= 1'b0;
            r_wr_addr     <= '0;
            r_done        <= 1'b0;
        end else begin
            r_update_vreg <= 1'b0;
            r_update_mask <= 1'b0;
            r_wr_flag     <= '0;
            r_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_job_valid) begin
                        r_vd        <= i_job_vd;
                        r_sew       <= i_job_sew;
                        r_vm        <= i_job_vm;
                        r_mask_dest <= i_job_mask_dest;
                        r_mask      <= i_mask[NBYTES-1:0];
                        r_vl_eff    <= w_vl_eff;
                        r_beat_idx  <= '0;
                        r_beat_last <= w_last;
                        if (w_vl_eff == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_res_valid) begin
                        r_wr_data     <= i_res_data;
                        // A normal job aimed at v0 still drains its beats but writes nothing.
                        r_wr_flag     <= (r_mask_dest || w_vd_nz) ? w_flag : '0;
                        r_wr_addr     <= r_mask_dest ? '0 : r_vd;
                        r_update_mask <= r_mask_dest;
                        r_update_vreg <= !r_mask_dest && w_vd_nz;
                        if (r_beat_idx == r_beat_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat_idx <= r_beat_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_job_ready   = (r_state == IDLE);
    assign o_busy        = (r_state == RUN);
    assign o_res_ready   = (r_state == RUN);
    assign o_wr_data     = r_wr_data;
    assign o_wr_flag     = r_wr_flag;
    assign o_update_vreg = r_update_vreg;
    assign o_update_mask = r_update_mask;
    assign o_wr_addr     = r_wr_addr;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vector_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_writeback_sequencer
// Brief   : Directed self-checking bench for vector_writeback_sequencer.
// Revision: 1.0  initial release
// ============================================================================
module tb_vector_writeback_sequencer;

    localparam int WIDTH = 32;
    localparam int VLEN  = 128;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_job_valid = 1'b0;
    logic               o_job_ready;
    logic [4:0]         i_job_vd = '0;
    logic [7:0]         i_job_vl = '0;
    logic [1:0]         i_job_sew = '0;
    logic               i_job_vm = 1'b0;
    logic               i_job_mask_dest = 1'b0;
    logic [VLEN-1:0]    i_mask = '0;
    logic               i_res_valid = 1'b0;
    logic               o_res_ready;
    logic [WIDTH-1:0]   i_res_data = '0;
    logic [WIDTH-1:0]   o_wr_data;
    logic [VLEN/8-1:0]  o_wr_flag;
    logic               o_update_vreg;
    logic               o_update_mask;
    logic [4:0]         o_wr_addr;
    logic               o_busy;
    logic               o_done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    vector_writeback_sequencer #(
        .WIDTH (WIDTH),
        .VLEN  (VLEN)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_job_valid     (i_job_valid),
        .o_job_ready     (o_job_ready),
        .i_job_vd        (i_job_vd),
        .i_job_vl        (i_job_vl),
        .i_job_sew       (i_job_sew),
        .i_job_vm        (i_job_vm),
        .i_job_mask_dest (i_job_mask_dest),
        .i_mask          (i_mask),
        .i_res_valid     (i_res_valid),
        .o_res_ready     (o_res_ready),
        .i_res_data      (i_res_data),
        .o_wr_data       (o_wr_data),
        .o_wr_flag       (o_wr_flag),
        .o_update_vreg   (o_update_vreg),
        .o_update_mask   (o_update_mask),
        .o_wr_addr       (o_wr_addr),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Issue one job, stream nb beats back to back and check every write.
    task automatic do_job(input string nm, input logic [4:0] vd, input logic [7:0] vl,
                          input logic [1:0] sew, input logic vm, input logic md,
                          input logic [127:0] mask, input int nb,
                          input logic [15:0] f0, input logic [15:0] f1,
                          input logic [15:0] f2, input logic [15:0] f3,
                          input logic [4:0] eaddr, input logic ev, input logic em);
        logic [15:0] ef [4];
        logic [31:0] d;
        ef[0] = f0; ef[1] = f1; ef[2] = f2; ef[3] = f3;
        i_job_valid     = 1'b1;
        i_job_vd        = vd;
        i_job_vl        = vl;
        i_job_sew       = sew;
        i_job_vm        = vm;
        i_job_mask_dest = md;
        i_mask          = mask;
        tick();
        i_job_valid = 1'b0;
        i_mask      = ~mask;
        chk({nm, " busy"}, o_busy, 1);
        chk({nm, " res_ready"}, o_res_ready, 1);
        chk({nm, " job_ready_low"}, o_job_ready, 0);
        chk({nm, " no_done_at_start"}, o_done, 0);
        chk({nm, " no_vreg_at_start"}, o_update_vreg, 0);
        for (int k = 0; k < nb; k++) begin
            d = {8'hC0, 3'b000, vd, 8'(nb), 8'(k)};
            i_res_valid = 1'b1;
            i_res_data  = d;
            tick();
            chk($sformatf("%s data%0d", nm, k), o_wr_data, d);
            chk($sformatf("%s flag%0d", nm, k), o_wr_flag, ef[k]);
            chk($sformatf("%s vreg%0d", nm, k), o_update_vreg, ev);
            chk($sformatf("%s umask%0d", nm, k), o_update_mask, em);
            chk($sformatf("%s addr%0d", nm, k), o_wr_addr, eaddr);
            chk($sformatf("%s done%0d", nm, k), o_done, (k == nb - 1) ? 1'b1 : 1'b0);
        end
        i_res_valid = 1'b0;
        chk({nm, " job_ready_end"}, o_job_ready, 1);
        chk({nm, " busy_end"}, o_busy, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst job_ready", o_job_ready, 1);
        chk("rst busy", o_busy, 0);
        chk("rst res_ready", o_res_ready, 0);
        chk("rst done", o_done, 0);
        chk("rst vreg", o_update_vreg, 0);
        chk("rst umask", o_update_mask, 0);
        chk("rst flag", o_wr_flag, 0);
        chk("rst data", o_wr_data, 0);
        chk("rst addr", o_wr_addr, 0);
        i_rst = 1'b0;
        tick();

        do_job("sew32", 5'd3, 8'd4, 2'b10, 1'b1, 1'b0, 128'h0, 4,
               16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 5'd3, 1'b1, 1'b0);
        do_job("sew8", 5'd5, 8'd5, 2'b00, 1'b1, 1'b0, 128'h0, 2,
               16'h000F, 16'h0010, 16'h0, 16'h0, 5'd5, 1'b1, 1'b0);
        do_job("sew16m", 5'd7, 8'd8, 2'b01, 1'b0, 1'b0, 128'hA5, 4,
               16'h0003, 16'h0030, 16'h0C00, 16'hC000, 5'd7, 1'b1, 1'b0);
        do_job("maskjob", 5'd9, 8'd40, 2'b10, 1'b1, 1'b1, 128'h0, 2,
               16'h000F, 16'h0010, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        do_job("vd0", 5'd0, 8'd4, 2'b10, 1'b1, 1'b0, 128'h0, 4,
               16'h0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        do_job("clamp", 5'd11, 8'd128, 2'b10, 1'b1, 1'b0, 128'h0, 4,
               16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 5'd11, 1'b1, 1'b0);
        do_job("allmasked", 5'd12, 8'd4, 2'b10, 1'b0, 1'b0, 128'h0, 4,
               16'h0, 16'h0, 16'h0, 16'h0, 5'd12, 1'b1, 1'b0);

        // Zero-length job followed by a job accepted on the done cycle.
        i_job_valid     = 1'b1;
        i_job_vd        = 5'd6;
        i_job_vl        = 8'd0;
        i_job_sew       = 2'b10;
        i_job_vm        = 1'b1;
        i_job_mask_dest = 1'b0;
        tick();
        i_job_valid = 1'b0;
        chk("vl0 done", o_done, 1);
        chk("vl0 job_ready", o_job_ready, 1);
        chk("vl0 busy", o_busy, 0);
        chk("vl0 vreg", o_update_vreg, 0);
        chk("vl0 umask", o_update_mask, 0);
        do_job("b2b_sew11", 5'd2, 8'd3, 2'b11, 1'b1, 1'b0, 128'h0, 3,
               16'h000F, 16'h00F0, 16'h0F00, 16'h0, 5'd2, 1'b1, 1'b0);

        // Reset after the first of four beats.
        i_job_valid = 1'b1;
        i_job_vd    = 5'd4;
        i_job_vl    = 8'd4;
        i_job_sew   = 2'b10;
        i_job_vm    = 1'b1;
        tick();
        i_job_valid = 1'b0;
        i_res_valid = 1'b1;
        i_res_data  = 32'h1234_5678;
        tick();
        chk("rstjob beat0 flag", o_wr_flag, 16'h000F);
        chk("rstjob beat0 vreg", o_update_vreg, 1);
        i_rst      = 1'b1;
        i_res_data = 32'h8765_4321;
        tick();
        i_rst = 1'b0;
        chk("rstjob vreg", o_update_vreg, 0);
        chk("rstjob flag", o_wr_flag, 0);
        chk("rstjob done", o_done, 0);
        chk("rstjob job_ready", o_job_ready, 1);
        chk("rstjob res_ready", o_res_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst vreg%0d", c), o_update_vreg, 0);
            chk($sformatf("post_rst done%0d", c), o_done, 0);
            chk($sformatf("post_rst res_ready%0d", c), o_res_ready, 0);
        end
        i_res_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
